// File: rtl/alu_pkg.sv
// Shared opcode encodings and result-flag helpers for the pipelined ALU.
package alu_pkg;
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_SHL = 3'b010;
  localparam logic [2:0] OP_SHR = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_EQ  = 3'b111;
endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: (a, b, op) -> (result, carry, signed overflow).
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [2:0]       op_i,
  output logic [WIDTH-1:0] res_o,
  output logic             carry_o,
  output logic             ovf_o
);
  localparam int SHW = $clog2(WIDTH);

  logic [SHW-1:0] w_s;
  logic           w_s_ok;
  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_dif;
  logic [WIDTH:0] w_shl;
  logic [WIDTH:0] w_shr;

  assign w_s    = b_i[SHW-1:0];
  assign w_s_ok = (32'(w_s) < 32'(WIDTH));
  assign w_sum  = {1'b0, a_i} + {1'b0, b_i};
  assign w_dif  = {1'b0, a_i} - {1'b0, b_i};
  // Extra bit on the far side of each shift catches the last bit shifted out.
  assign w_shl  = {1'b0, a_i} << w_s;
  assign w_shr  = {a_i, 1'b0} >> w_s;

  always_comb begin
    res_o   = '0;
    carry_o = 1'b0;
    ovf_o   = 1'b0;
    unique case (op_i)
      OP_ADD: begin
        res_o   = w_sum[WIDTH-1:0];
        carry_o = w_sum[WIDTH];
        ovf_o   = (a_i[WIDTH-1] == b_i[WIDTH-1]) &
                  (w_sum[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_SUB: begin
        res_o   = w_dif[WIDTH-1:0];
        carry_o = w_dif[WIDTH];
        ovf_o   = (a_i[WIDTH-1] != b_i[WIDTH-1]) &
                  (w_dif[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_SHL: begin
        if (w_s_ok) begin
          res_o   = w_shl[WIDTH-1:0];
          carry_o = w_shl[WIDTH];
        end
      end
      OP_SHR: begin
        if (w_s_ok) begin
          res_o   = w_shr[WIDTH:1];
          carry_o = w_shr[0];
        end
      end
      OP_AND: res_o = a_i & b_i;
      OP_OR:  res_o = a_i | b_i;
      OP_XOR: res_o = a_i ^ b_i;
      OP_EQ:  res_o = {{(WIDTH-1){1'b0}}, (a_i == b_i)};
      default: res_o = '0;
    endcase
  end
endmodule

// File: rtl/alu_pipe.sv
// Two-stage ALU pipeline: operand register, then result register,
// with valid/ready on both sides and a pass-through tag.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [2:0]       op_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_o,
  output logic             carry_o,
  output logic             zero_o,
  output logic             neg_o,
  output logic             ovf_o,
  output logic [TAG_W-1:0] tag_o
);
  logic             r_s1_valid;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_op;
  logic [TAG_W-1:0] r_s1_tag;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic             r_zero;
  logic             r_neg;
  logic             r_ovf;
  logic [TAG_W-1:0] r_tag;

  logic             w_adv2;
  logic             w_acc;
  logic [WIDTH-1:0] w_res;
  logic             w_carry;
  logic             w_ovf;

  assign w_adv2   = r_s1_valid & (~r_out_valid | out_ready);
  assign in_ready = ~r_s1_valid | w_adv2;
  assign w_acc    = in_valid & in_ready;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a_i     (r_a),
    .b_i     (r_b),
    .op_i    (r_op),
    .res_o   (w_res),
    .carry_o (w_carry),
    .ovf_o   (w_ovf)
  );

  // Operands only load on accept, so idle-cycle X never reaches the core.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_op       <= OP_ADD;
      r_s1_tag   <= '0;
    end else if (w_acc) begin
      r_s1_valid <= 1'b1;
      r_a        <= a_i;
      r_b        <= b_i;
      r_op       <= op_i;
      r_s1_tag   <= tag_i;
    end else if (w_adv2) begin
      r_s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_res       <= '0;
      r_carry     <= 1'b0;
      r_zero      <= 1'b0;
      r_neg       <= 1'b0;
      r_ovf       <= 1'b0;
      r_tag       <= '0;
    end else if (w_adv2) begin
      r_out_valid <= 1'b1;
      r_res       <= w_res;
      r_carry     <= w_carry;
      r_zero      <= (w_res == '0);
      r_neg       <= w_res[WIDTH-1];
      r_ovf       <= w_ovf;
      r_tag       <= r_s1_tag;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign alu_o     = r_res;
  assign carry_o   = r_carry;
  assign zero_o    = r_zero;
  assign neg_o     = r_neg;
  assign ovf_o     = r_ovf;
  assign tag_o     = r_tag;
endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe at WIDTH=8 and WIDTH=16.
module tb_alu_pipe;
  import alu_pkg::*;

  typedef struct packed {
    logic [15:0] r;
    logic [3:0]  f;
    logic [3:0]  t;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       iv8 = 1'b0, ir8, ov8, or8 = 1'b1;
  logic [7:0] a8 = '0, b8 = '0, alu8;
  logic [2:0] op8 = '0;
  logic [3:0] tg8 = '0, tgo8;
  logic       c8, z8, n8, v8;

  logic        iv16 = 1'b0, ir16, ov16, or16 = 1'b1;
  logic [15:0] a16 = '0, b16 = '0, alu16;
  logic [2:0]  op16 = '0;
  logic [3:0]  tg16 = '0, tgo16;
  logic        c16, z16, n16, v16;

  alu_pipe #(.WIDTH(8), .TAG_W(4)) u8 (
    .clk(clk), .reset(reset),
    .in_valid(iv8), .in_ready(ir8),
    .a_i(a8), .b_i(b8), .op_i(op8), .tag_i(tg8),
    .out_valid(ov8), .out_ready(or8),
    .alu_o(alu8), .carry_o(c8), .zero_o(z8),
    .neg_o(n8), .ovf_o(v8), .tag_o(tgo8)
  );

  alu_pipe #(.WIDTH(16), .TAG_W(4)) u16 (
    .clk(clk), .reset(reset),
    .in_valid(iv16), .in_ready(ir16),
    .a_i(a16), .b_i(b16), .op_i(op16), .tag_i(tg16),
    .out_valid(ov16), .out_ready(or16),
    .alu_o(alu16), .carry_o(c16), .zero_o(z16),
    .neg_o(n16), .ovf_o(v16), .tag_o(tgo16)
  );

  exp_t q8[$];
  exp_t q16[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   stall_cnt = 0;
  bit   hold = 1'b0;
  bit   saw_block = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h expected=%h", nm, got, exp);
  endtask

  always @(negedge clk) begin
    if (stall_cnt > 0) begin
      or8 = 1'b0;
      stall_cnt--;
    end else begin
      or8 = !hold;
    end
  end

  // Monitors sample mid-low-phase, after all negedge drives settle.
  bit          st8 = 1'b0;
  logic [27:0] pv8;
  always @(negedge clk) begin
    logic [27:0] got;
    exp_t e;
    #3;
    got = {8'h00, alu8, c8, z8, n8, v8, tgo8};
    if (reset) st8 = 1'b0;
    else begin
      if (st8 && ov8) chk("hold8", {4'h0, got}, {4'h0, pv8});
      if (ov8 && or8) begin
        if (q8.size() == 0) begin
          n_chk++;
          $display("FAIL unexp8 got=%h expected=none", got);
        end else begin
          e = q8.pop_front();
          chk("res8", {4'h0, got}, {4'h0, e});
        end
      end
      st8 = ov8 && !or8;
      pv8 = got;
    end
  end

  always @(negedge clk) begin
    logic [27:0] got;
    exp_t e;
    #3;
    got = {alu16, c16, z16, n16, v16, tgo16};
    if (!reset && ov16 && or16) begin
      if (q16.size() == 0) begin
        n_chk++;
        $display("FAIL unexp16 got=%h expected=none", got);
      end else begin
        e = q16.pop_front();
        chk("res16", {4'h0, got}, {4'h0, e});
      end
    end
  end

  task automatic issue(input bit w16, input logic [2:0] op,
                       input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] tg, input logic [15:0] er,
                       input logic [3:0] ef);
    bit ok;
    int n;
    n = 0;
    ok = 1'b0;
    @(negedge clk);
    if (w16) begin
      iv16 = 1'b1; a16 = a; b16 = b; op16 = op; tg16 = tg;
    end else begin
      iv8 = 1'b1; a8 = a[7:0]; b8 = b[7:0]; op8 = op; tg8 = tg;
    end
    while (1) begin
      #1;
      ok = w16 ? ir16 : ir8;
      if (!ok) saw_block = 1'b1;
      @(posedge clk);
      if (ok) break;
      n++;
      if (n > 50) begin
        n_chk++;
        $display("FAIL accept_timeout got=in_ready0 expected=accept");
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      if (w16) q16.push_back('{er, ef, tg});
      else     q8.push_back('{er, ef, tg});
    end
    #1;
    iv8  = 1'b0;
    iv16 = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q8.size() != 0 || q16.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain", q8.size() + q16.size(), 0);
  endtask

  // flags packed {carry, zero, neg, ovf}
  logic [2:0] t4op[8] = '{OP_ADD, OP_SUB, OP_XOR, OP_OR,
                          OP_AND, OP_SHR, OP_SHL, OP_EQ};
  logic [7:0] t4a[8]  = '{8'h10, 8'h40, 8'h0F, 8'h01,
                          8'hFF, 8'hF0, 8'h03, 8'h11};
  logic [7:0] t4b[8]  = '{8'h20, 8'h10, 8'hFF, 8'h02,
                          8'h0F, 8'h04, 8'h02, 8'h12};
  logic [7:0] t4r[8]  = '{8'h30, 8'h30, 8'hF0, 8'h03,
                          8'h0F, 8'h0F, 8'h0C, 8'h00};
  logic [3:0] t4f[8]  = '{4'b0000, 4'b0000, 4'b0010, 4'b0000,
                          4'b0000, 4'b0000, 4'b0000, 4'b0100};

  initial begin
    logic [15:0] ra, rb, rr;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", ov8, 0);
    chk("rst_alu", {alu8, c8, z8, n8, v8, tgo8}, 0);
    chk("rst_in_ready", ir8, 1);
    reset = 1'b0;

    issue(0, OP_ADD, 16'h05, 16'h03, 4'h1, 16'h08, 4'b0000);
    issue(0, OP_ADD, 16'hFF, 16'h01, 4'h2, 16'h00, 4'b1100);
    issue(0, OP_ADD, 16'h7F, 16'h01, 4'h3, 16'h80, 4'b0011);
    issue(0, OP_SUB, 16'h05, 16'h03, 4'h4, 16'h02, 4'b0000);
    issue(0, OP_SUB, 16'h03, 16'h05, 4'h5, 16'hFE, 4'b1010);
    issue(0, OP_SUB, 16'h80, 16'h01, 4'h6, 16'h7F, 4'b0001);
    issue(0, OP_EQ,  16'h05, 16'h05, 4'h7, 16'h01, 4'b0000);
    issue(0, OP_EQ,  16'h05, 16'h03, 4'h8, 16'h00, 4'b0100);
    issue(0, OP_SHL, 16'h05, 16'h03, 4'h9, 16'h28, 4'b0000);
    issue(0, OP_SHL, 16'h81, 16'h01, 4'hA, 16'h02, 4'b1000);
    issue(0, OP_SHR, 16'h05, 16'h01, 4'hB, 16'h02, 4'b1000);
    issue(0, OP_SHL, 16'hA5, 16'h00, 4'hC, 16'hA5, 4'b0010);
    issue(0, OP_SHR, 16'h80, 16'h07, 4'hD, 16'h01, 4'b0000);
    issue(0, OP_AND, 16'hF0, 16'h3C, 4'hE, 16'h30, 4'b0000);
    issue(0, OP_OR,  16'hF0, 16'h0F, 4'hF, 16'hFF, 4'b0010);
    issue(0, OP_XOR, 16'hAA, 16'hAA, 4'h0, 16'h00, 4'b0100);
    drain();

    saw_block = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k == 3) stall_cnt = 3;
      issue(0, t4op[k], {8'h00, t4a[k]}, {8'h00, t4b[k]},
            4'($urandom_range(0, 15)), {8'h00, t4r[k]}, t4f[k]);
    end
    drain();
    chk("in_ready_blocked", saw_block, 1);

    hold = 1'b1;
    issue(0, OP_ADD, 16'h01, 16'h01, 4'h1, 16'h02, 4'b0000);
    issue(0, OP_ADD, 16'h02, 16'h02, 4'h2, 16'h04, 4'b0000);
    @(negedge clk);
    reset = 1'b1;
    q8.delete();
    @(negedge clk);
    #1;
    chk("rst5_out_valid", ov8, 0);
    chk("rst5_alu", alu8, 0);
    chk("rst5_in_ready", ir8, 1);
    reset = 1'b0;
    hold = 1'b0;
    repeat (6) @(negedge clk);

    issue(1, OP_ADD, 16'hFFFF, 16'h0001, 4'h3, 16'h0000, 4'b1100);
    issue(1, OP_SHL, 16'h0001, 16'h000F, 4'h4, 16'h8000, 4'b0010);
    issue(1, OP_SHR, 16'h8000, 16'h000F, 4'h5, 16'h0001, 4'b0000);
    for (int k = 0; k < 6; k++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      case (k % 3)
        0: rr = ra & rb;
        1: rr = ra | rb;
        default: rr = ra ^ rb;
      endcase
      issue(1, (k % 3 == 0) ? OP_AND : (k % 3 == 1) ? OP_OR : OP_XOR,
            ra, rb, 4'(k), rr, {1'b0, rr == 16'h0, rr[15], 1'b0});
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
